// File: rtl/systolic_cmd_sched_pkg.sv
// Shared constants, response payload and helpers for the systolic command scheduler.
package systolic_cmd_sched_pkg;

  localparam logic [2:0] SA_OP_CONF = 3'b000;
  localparam logic [2:0] SA_OP_CONV = 3'b001;
  localparam logic [2:0] SA_OP_MAT  = 3'b010;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_BEATS   = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
  localparam logic [1:0] STAT_BADCFG  = 2'b11;

  localparam int unsigned BEATS_W = 10;
  localparam logic [BEATS_W-1:0] MAX_BEATS = 10'd1023;

  typedef struct packed {
    logic [1:0]         status;
    logic [BEATS_W-1:0] beats;
  } resp_t;

  // Saturating beat counter step.
  function automatic logic [BEATS_W-1:0] beats_inc(input logic [BEATS_W-1:0] b, input logic v);
    return (v && (b != MAX_BEATS)) ? b + BEATS_W'(1) : b;
  endfunction

endpackage

// File: rtl/systolic_cmd_sched_desc_fifo.sv
// Synchronous descriptor FIFO; simultaneous push and pop are both honoured.
module systolic_cmd_sched_desc_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage is not reset; only the pointers and occupancy matter.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/systolic_cmd_sched.sv
// Queues host job descriptors and sequences the systolic feeder config/start
// handshakes, counting output beats and returning one status per job.
module systolic_cmd_sched
  import systolic_cmd_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DIM_W  = 8,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned TMO_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_conv,
  input  logic [ADDR_W-1:0]    cmd_uni_addr,
  input  logic [ADDR_W-1:0]    cmd_wei_addr,
  input  logic [3*DIM_W-1:0]   cmd_uni_dim,
  input  logic [3*DIM_W-1:0]   cmd_wei_dim,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [1:0]           resp_status,
  output logic [BEATS_W-1:0]   resp_beats,
  output logic                 busy,
  output logic [2:0]           sa_op,
  output logic                 sa_cfg_valid,
  output logic [ADDR_W-1:0]    sa_uni_addr,
  output logic [ADDR_W-1:0]    sa_wei_addr,
  output logic [3*DIM_W-1:0]   sa_uni_dim,
  output logic [3*DIM_W-1:0]   sa_wei_dim,
  input  logic                 sa_ack,
  input  logic                 sa_done,
  input  logic                 sa_do_valid
);

  localparam int unsigned DESC_W = 1 + 2*ADDR_W + 6*DIM_W;
  localparam int unsigned EXP_W  = 2*DIM_W + 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_CFG     = 3'd2;
  localparam logic [2:0] S_CFG_CLR = 3'd3;
  localparam logic [2:0] S_START   = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  logic [2:0]         r_state;
  logic [DESC_W-1:0]  r_job;
  logic [BEATS_W-1:0] r_beats;
  logic [TMO_W-1:0]   r_wdt;
  resp_t              r_resp;
  logic               r_resp_valid;
  logic [2:0]         r_sa_op;
  logic               r_sa_cfg_valid;
  logic [ADDR_W-1:0]  r_sa_uni_addr;
  logic [ADDR_W-1:0]  r_sa_wei_addr;
  logic [3*DIM_W-1:0] r_sa_uni_dim;
  logic [3*DIM_W-1:0] r_sa_wei_dim;

  logic [2:0]         w_state_nxt;
  logic [BEATS_W-1:0] w_beats_nxt;
  logic [BEATS_W-1:0] w_beats_inc;
  logic [TMO_W-1:0]   w_wdt_nxt;
  resp_t              w_resp_nxt;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [DESC_W-1:0]  w_fifo_din;
  logic [DESC_W-1:0]  w_fifo_dout;
  logic               w_job_conv;
  logic [ADDR_W-1:0]  w_job_uni_addr;
  logic [ADDR_W-1:0]  w_job_wei_addr;
  logic [3*DIM_W-1:0] w_job_uni_dim;
  logic [3*DIM_W-1:0] w_job_wei_dim;
  logic [EXP_W-1:0]   w_exp;
  logic               w_bad_cfg;
  logic               w_active;
  logic               w_tmo;

  assign w_push     = cmd_valid & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_fifo_din = {cmd_conv, cmd_uni_addr, cmd_wei_addr, cmd_uni_dim, cmd_wei_dim};

  systolic_cmd_sched_desc_fifo #(
    .W     (DESC_W),
    .DEPTH (QDEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_fifo_din),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_job_conv     = r_job[DESC_W-1];
  assign w_job_uni_addr = r_job[DESC_W-2 -: ADDR_W];
  assign w_job_wei_addr = r_job[DESC_W-2-ADDR_W -: ADDR_W];
  assign w_job_uni_dim  = r_job[6*DIM_W-1 -: 3*DIM_W];
  assign w_job_wei_dim  = r_job[3*DIM_W-1:0];

  // Expected beats: unified channels * rows, tripled for conv jobs.
  assign w_exp = EXP_W'(w_job_uni_dim[3*DIM_W-1 -: DIM_W]) *
                 EXP_W'(w_job_uni_dim[2*DIM_W-1 -: DIM_W]) *
                 (w_job_conv ? EXP_W'(3) : EXP_W'(1));
  assign w_bad_cfg = (w_exp == '0) || (w_exp > EXP_W'(MAX_BEATS));

  assign w_beats_inc = beats_inc(r_beats, sa_do_valid);
  assign w_active    = (r_state == S_CFG) || (r_state == S_CFG_CLR) ||
                       (r_state == S_START) || (r_state == S_RUN);
  assign w_tmo       = (r_wdt == '1) & ~sa_ack & ~sa_do_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_beats_nxt = r_beats;
    w_resp_nxt  = r_resp;
    w_wdt_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        w_beats_nxt = '0;
        if (!w_empty) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_bad_cfg) begin
          w_state_nxt       = S_RESP;
          w_resp_nxt.status = STAT_BADCFG;
          w_resp_nxt.beats  = '0;
        end else begin
          w_state_nxt = S_CFG;
        end
      end
      S_CFG: begin
        if (sa_ack) begin
          w_state_nxt = S_CFG_CLR;
        end else if (w_tmo) begin
          w_state_nxt       = S_RESP;
          w_resp_nxt.status = STAT_TIMEOUT;
          w_resp_nxt.beats  = r_beats;
        end
      end
      S_CFG_CLR: begin
        // A held ack keeps the watchdog clear, so only its release matters here.
        if (!sa_ack) w_state_nxt = S_START;
      end
      S_START: begin
        if (sa_ack) begin
          w_state_nxt = S_RUN;
        end else if (w_tmo) begin
          w_state_nxt       = S_RESP;
          w_resp_nxt.status = STAT_TIMEOUT;
          w_resp_nxt.beats  = r_beats;
        end
      end
      S_RUN: begin
        w_beats_nxt = w_beats_inc;
        if (sa_done) begin
          w_state_nxt       = S_RESP;
          w_resp_nxt.status = (EXP_W'(w_beats_inc) == w_exp) ? STAT_OK : STAT_BEATS;
          w_resp_nxt.beats  = w_beats_inc;
        end else if (w_tmo) begin
          w_state_nxt       = S_RESP;
          w_resp_nxt.status = STAT_TIMEOUT;
          w_resp_nxt.beats  = w_beats_inc;
        end
      end
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_active && (w_state_nxt == r_state) && !sa_ack && !sa_do_valid)
      w_wdt_nxt = r_wdt + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_job          <= '0;
      r_beats        <= '0;
      r_wdt          <= '0;
      r_resp         <= '0;
      r_resp_valid   <= 1'b0;
      r_sa_op        <= SA_OP_CONF;
      r_sa_cfg_valid <= 1'b0;
      r_sa_uni_addr  <= '0;
      r_sa_wei_addr  <= '0;
      r_sa_uni_dim   <= '0;
      r_sa_wei_dim   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_beats        <= w_beats_nxt;
      r_wdt          <= w_wdt_nxt;
      r_resp         <= w_resp_nxt;
      r_resp_valid   <= (w_state_nxt == S_RESP);
      r_sa_cfg_valid <= (w_state_nxt == S_CFG) || (w_state_nxt == S_START);
      r_sa_op        <= (w_state_nxt == S_START) ? (w_job_conv ? SA_OP_CONV : SA_OP_MAT)
                                                 : SA_OP_CONF;
      if (w_pop) r_job <= w_fifo_dout;
      // Feeder address/dimension lines are captured once and held through the job.
      if ((r_state == S_CHECK) && (w_state_nxt == S_CFG)) begin
        r_sa_uni_addr <= w_job_uni_addr;
        r_sa_wei_addr <= w_job_wei_addr;
        r_sa_uni_dim  <= w_job_uni_dim;
        r_sa_wei_dim  <= w_job_wei_dim;
      end
    end
  end

  assign cmd_ready    = ~w_full;
  assign busy         = (r_state != S_IDLE) | ~w_empty;
  assign resp_valid   = r_resp_valid;
  assign resp_status  = r_resp.status;
  assign resp_beats   = r_resp.beats;
  assign sa_op        = r_sa_op;
  assign sa_cfg_valid = r_sa_cfg_valid;
  assign sa_uni_addr  = r_sa_uni_addr;
  assign sa_wei_addr  = r_sa_wei_addr;
  assign sa_uni_dim   = r_sa_uni_dim;
  assign sa_wei_dim   = r_sa_wei_dim;

endmodule

// File: tb/tb_systolic_cmd_sched.sv
// Directed bench for systolic_cmd_sched with a small behavioural feeder model.
module tb_systolic_cmd_sched;
  import systolic_cmd_sched_pkg::*;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DIM_W  = 8;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned TMO_W  = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic                 cmd_conv = 1'b0;
  logic [ADDR_W-1:0]    cmd_uni_addr = '0;
  logic [ADDR_W-1:0]    cmd_wei_addr = '0;
  logic [3*DIM_W-1:0]   cmd_uni_dim = '0;
  logic [3*DIM_W-1:0]   cmd_wei_dim = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [1:0]           resp_status;
  logic [9:0]           resp_beats;
  logic                 busy;
  logic [2:0]           sa_op;
  logic                 sa_cfg_valid;
  logic [ADDR_W-1:0]    sa_uni_addr;
  logic [ADDR_W-1:0]    sa_wei_addr;
  logic [3*DIM_W-1:0]   sa_uni_dim;
  logic [3*DIM_W-1:0]   sa_wei_dim;
  logic                 sa_ack = 1'b0;
  logic                 sa_done = 1'b0;
  logic                 sa_do_valid = 1'b0;

  always #5 clk = ~clk;

  systolic_cmd_sched #(
    .ADDR_W (ADDR_W), .DIM_W (DIM_W), .QDEPTH (QDEPTH), .TMO_W (TMO_W)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_conv (cmd_conv),
    .cmd_uni_addr (cmd_uni_addr), .cmd_wei_addr (cmd_wei_addr),
    .cmd_uni_dim (cmd_uni_dim), .cmd_wei_dim (cmd_wei_dim),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_status (resp_status), .resp_beats (resp_beats), .busy (busy),
    .sa_op (sa_op), .sa_cfg_valid (sa_cfg_valid),
    .sa_uni_addr (sa_uni_addr), .sa_wei_addr (sa_wei_addr),
    .sa_uni_dim (sa_uni_dim), .sa_wei_dim (sa_wei_dim),
    .sa_ack (sa_ack), .sa_done (sa_done), .sa_do_valid (sa_do_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int model_beats = 0;
  bit model_done  = 1'b1;
  int n_cfg_hs = 0, n_start_hs = 0, n_cfgv = 0, since_dov = 0, resp_since = 0;
  logic [2:0]         start_op = '0;
  logic [ADDR_W-1:0]  cap_uni_addr = '0, cap_wei_addr = '0;
  logic [3*DIM_W-1:0] cap_uni_dim = '0;

  // Handshake monitor: sees pre-edge values of the registered DUT outputs.
  always @(posedge clk) begin
    if (sa_cfg_valid) n_cfgv++;
    if (sa_do_valid) since_dov = 0; else since_dov++;
    if (sa_cfg_valid && sa_ack) begin
      if (sa_op == 3'b000) begin
        n_cfg_hs++;
        cap_uni_addr = sa_uni_addr;
        cap_wei_addr = sa_wei_addr;
        cap_uni_dim  = sa_uni_dim;
      end else begin
        n_start_hs++;
        start_op = sa_op;
      end
    end
  end

  // Feeder model: ack follows cfg_valid; after a start, emit beats then optionally done.
  int run_left = 0, last_start = 0;
  bit done_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      sa_ack = 1'b0; sa_do_valid = 1'b0; sa_done = 1'b0;
      run_left = 0; done_pend = 1'b0; last_start = n_start_hs;
    end else begin
      sa_ack = sa_cfg_valid;
      sa_do_valid = 1'b0;
      sa_done = 1'b0;
      if (n_start_hs != last_start) begin
        last_start = n_start_hs;
        run_left   = model_beats;
        done_pend  = model_done;
      end
      if (run_left > 0) begin
        sa_do_valid = 1'b1;
        run_left--;
      end else if (done_pend) begin
        sa_done   = 1'b1;
        done_pend = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic conv, input logic [7:0] ch, input logic [7:0] row,
                      input logic [ADDR_W-1:0] ua);
    int n = 0;
    cmd_conv     = conv;
    cmd_uni_addr = ua;
    cmd_wei_addr = ua + 12'h100;
    cmd_uni_dim  = {ch, row, 8'd7};
    cmd_wei_dim  = {8'd3, 8'd3, 8'd1};
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic [1:0] st, input logic [9:0] bts,
                           input int stall);
    int n = 0;
    logic [1:0] st0;
    logic [9:0] b0;
    bit stable = 1'b1;
    while (!resp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    resp_since = since_dov;
    check({tag, " valid"}, 32'(resp_valid), 1);
    st0 = resp_status;
    b0  = resp_beats;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_status !== st0 || resp_beats !== b0) stable = 1'b0;
    end
    if (stall > 0) check({tag, " stall"}, 32'(stable), 1);
    check({tag, " status"}, 32'(resp_status), 32'(st));
    check({tag, " beats"}, 32'(resp_beats), 32'(bts));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " drop"}, 32'(resp_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s_cfg, s_start, s_cfgv, any_resp;
    repeat (3) @(negedge clk);
    check("rst cmd_ready", 32'(cmd_ready), 1);
    check("rst busy", 32'(busy), 0);
    check("rst resp_valid", 32'(resp_valid), 0);
    check("rst cfg_valid", 32'(sa_cfg_valid), 0);
    check("rst sa_op", 32'(sa_op), 0);
    check("rst status", 32'(resp_status), 0);
    check("rst beats", 32'(resp_beats), 0);
    check("rst uni_addr", 32'(sa_uni_addr), 0);
    rst = 1'b1;
    @(negedge clk);

    // Matrix 4x4: 16 beats, exact match.
    model_beats = 16; model_done = 1'b1;
    s_cfg = n_cfg_hs; s_start = n_start_hs;
    push(1'b0, 8'd4, 8'd4, 12'h123);
    wait_resp("t1", STAT_OK, 10'd16, 0);
    check("t1 cfg hs", 32'(n_cfg_hs - s_cfg), 1);
    check("t1 start hs", 32'(n_start_hs - s_start), 1);
    check("t1 start op", 32'(start_op), 32'(3'b010));
    check("t1 uni addr", 32'(cap_uni_addr), 32'h123);
    check("t1 wei addr", 32'(cap_wei_addr), 32'h223);
    check("t1 uni dim", 32'(cap_uni_dim), 32'h040407);
    check("t1 idle busy", 32'(busy), 0);

    // Conv 2x3: expected 18, feeder gives 17.
    model_beats = 17;
    push(1'b1, 8'd2, 8'd3, 12'h010);
    wait_resp("t2", STAT_BEATS, 10'd17, 2);
    check("t2 start op", 32'(start_op), 32'(3'b001));

    // Zero channels and oversize conv job are both rejected untouched.
    s_cfgv = n_cfgv;
    push(1'b0, 8'd0, 8'd5, 12'h020);
    wait_resp("t3a", STAT_BADCFG, 10'd0, 0);
    push(1'b1, 8'd64, 8'd32, 12'h030);
    wait_resp("t3b", STAT_BADCFG, 10'd0, 0);
    check("t3 no cfg_valid", 32'(n_cfgv - s_cfgv), 0);

    // Five back-to-back pushes: first is popped, the remaining four fill the queue.
    model_beats = 3;
    push(1'b0, 8'd1, 8'd3, 12'h041);
    push(1'b1, 8'd1, 8'd1, 12'h042);
    push(1'b0, 8'd0, 8'd3, 12'h043);
    push(1'b0, 8'd3, 8'd1, 12'h044);
    push(1'b1, 8'd1, 8'd2, 12'h045);
    check("t4 full ready", 32'(cmd_ready), 0);
    check("t4 busy", 32'(busy), 1);
    wait_resp("t4 j0", STAT_OK, 10'd3, 3);
    wait_resp("t4 j1", STAT_OK, 10'd3, 3);
    wait_resp("t4 j2", STAT_BADCFG, 10'd0, 3);
    wait_resp("t4 j3", STAT_OK, 10'd3, 3);
    wait_resp("t4 j4", STAT_BEATS, 10'd3, 3);
    check("t4 drained busy", 32'(busy), 0);

    // Feeder never signals done: watchdog fires after 63 idle cycles.
    model_beats = 5; model_done = 1'b0;
    push(1'b0, 8'd2, 8'd10, 12'h050);
    wait_resp("t5", STAT_TIMEOUT, 10'd5, 0);
    check("t5 idle cycles", 32'(resp_since), 64);
    check("t5 cfg_valid", 32'(sa_cfg_valid), 0);
    model_done = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset mid-run with a second job queued.
    model_beats = 100;
    s_start = n_start_hs;
    push(1'b0, 8'd10, 8'd10, 12'h060);
    push(1'b0, 8'd2, 8'd2, 12'h061);
    repeat (15) @(negedge clk);
    check("t6 running", 32'(n_start_hs - s_start), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6 cmd_ready", 32'(cmd_ready), 1);
    check("t6 busy", 32'(busy), 0);
    check("t6 resp_valid", 32'(resp_valid), 0);
    check("t6 cfg_valid", 32'(sa_cfg_valid), 0);
    check("t6 sa_op", 32'(sa_op), 0);
    check("t6 beats", 32'(resp_beats), 0);
    check("t6 uni_addr", 32'(sa_uni_addr), 0);
    rst = 1'b1;
    any_resp = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || busy) any_resp++;
    end
    check("t6 quiet", 32'(any_resp), 0);
    model_beats = 9;
    push(1'b0, 8'd3, 8'd3, 12'h070);
    wait_resp("t6 new", STAT_OK, 10'd9, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
